// File: rtl/seven_seg_pkg.sv
// Shared glyph constants and the value-to-segment decode for the 7-segment scanner.
// Segment order is gfedcba, active-low (0 = segment lit).
package seven_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] GLYPH_ERR = 7'b0000110;

  function automatic logic [6:0] seg_decode(input logic [3:0] value, input logic hex_mode);
    logic [6:0] glyph;
    case (value)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
    // Non-decimal values collapse to the error glyph unless hex display is enabled.
    if (!hex_mode && value >= 4'd10) glyph = GLYPH_ERR;
    return glyph;
  endfunction

endpackage

// File: rtl/seg_glyph_dec.sv
// Combinational digit value to active-low gfedcba glyph decoder.
module seg_glyph_dec
  import seven_seg_pkg::*;
#(
  parameter int HEX_MODE = 1
) (
  input  logic [3:0] i_value,
  output logic [6:0] o_glyph
);

  assign o_glyph = seg_decode(i_value, HEX_MODE != 0);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed common-anode 7-segment scanner with frame-synchronous input snapshot,
// blinking, blanking, leading-zero suppression and PWM brightness.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int DIV_RATIO = 100000,
  parameter int PWM_BITS  = 4,
  parameter int BLINK_DIV = 50,
  parameter int HEX_MODE  = 1
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [4*N_DIGITS-1:0]   DIGITS,
  input  logic [N_DIGITS-1:0]     DP_IN,
  input  logic [N_DIGITS-1:0]     BLANK,
  input  logic [N_DIGITS-1:0]     BLINK_EN,
  input  logic                    LZ_SUPPRESS,
  input  logic [PWM_BITS-1:0]     BRIGHTNESS,
  output logic [6:0]              SEG_OUT,
  output logic                    DP_OUT,
  output logic [N_DIGITS-1:0]     ANODE,
  output logic                    FRAME_TICK
);

  localparam int CW = $clog2(DIV_RATIO + 1);
  localparam int IW = $clog2(N_DIGITS);
  localparam int BW = $clog2(BLINK_DIV + 1);

  logic [CW-1:0]         r_count;
  logic [IW-1:0]         r_idx;
  logic [PWM_BITS-1:0]   r_pwm_cnt;
  logic [BW-1:0]         r_blink_cnt;
  logic                  r_blink_phase;
  logic [4*N_DIGITS-1:0] r_snap_digits;
  logic [N_DIGITS-1:0]   r_snap_dp;
  logic [N_DIGITS-1:0]   r_snap_blank;
  logic [N_DIGITS-1:0]   r_snap_blink;
  logic                  r_snap_lz;

  logic                  w_carry;
  logic                  w_frame;
  logic [N_DIGITS-1:0]   w_sel;
  logic [N_DIGITS-1:0]   w_suppress;
  logic                  w_zero_run;
  logic [3:0]            w_digit_val;
  logic [6:0]            w_glyph;
  logic                  w_cur_supp;
  logic                  w_lit;

  assign w_carry    = (r_count == CW'(DIV_RATIO));
  assign w_frame    = w_carry && (r_idx == IW'(N_DIGITS - 1));
  assign FRAME_TICK = w_frame;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_count   <= '0;
      r_idx     <= '0;
      r_pwm_cnt <= '0;
    end else if (w_carry) begin
      r_count   <= '0;
      r_pwm_cnt <= '0;
      r_idx     <= (r_idx == IW'(N_DIGITS - 1)) ? '0 : r_idx + 1'b1;
    end else begin
      r_count   <= r_count + 1'b1;
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
    end
  end

  // NOTE: the snapshot bank is reset explicitly so the first frame after reset shows zeros.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_snap_digits <= '0;
      r_snap_dp     <= '0;
      r_snap_blank  <= '0;
      r_snap_blink  <= '0;
      r_snap_lz     <= 1'b0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_frame) begin
      r_snap_digits <= DIGITS;
      r_snap_dp     <= DP_IN;
      r_snap_blank  <= BLANK;
      r_snap_blink  <= BLINK_EN;
      r_snap_lz     <= LZ_SUPPRESS;
      if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_sel       = '0;
    w_suppress  = '0;
    w_zero_run  = 1'b1;
    w_digit_val = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (r_idx == IW'(k)) begin
        w_sel[k]    = 1'b1;
        w_digit_val = r_snap_digits[4*k +: 4];
      end
    end
    // Walk down from the most significant digit; digit 0 is never suppressed.
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      w_zero_run    = w_zero_run && (r_snap_digits[4*k +: 4] == 4'd0);
      w_suppress[k] = r_snap_lz && w_zero_run;
    end
  end

  seg_glyph_dec #(.HEX_MODE(HEX_MODE)) u_glyph_dec (
    .i_value (w_digit_val),
    .o_glyph (w_glyph)
  );

  assign w_cur_supp = |(w_suppress & w_sel);
  assign w_lit      = (r_pwm_cnt <= BRIGHTNESS)
                   && !(|(r_snap_blank & w_sel))
                   && !(r_blink_phase && |(r_snap_blink & w_sel))
                   && (!w_cur_supp || |(r_snap_dp & w_sel));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ANODE   <= '1;
      SEG_OUT <= SEG_BLANK;
      DP_OUT  <= 1'b1;
    end else begin
      ANODE   <= w_lit ? ~w_sel : '1;
      SEG_OUT <= (w_lit && !w_cur_supp) ? w_glyph : SEG_BLANK;
      DP_OUT  <= !(w_lit && |(r_snap_dp & w_sel));
    end
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
- Parametrised multiplexed 7-segment display controller for N common-anode digits (active-low segments and anodes).
- Adds the following over the fixed 4-digit scanner:
  - decimal points
  - per-digit blanking and blinking
  - leading-zero suppression
  - PWM brightness control
  - selectable hex or error glyphs
  - frame-synchronous input snapshot, so the display never shows a mix of old and new digits mid-frame
- Sits between the datapath (BCD/hex values) and the board pins.

Parameters:
- N_DIGITS, 4: number of digits scanned (2..8).
- DIV_RATIO, 100000: prescaler terminal count; one digit slot lasts DIV_RATIO+1 CLK cycles.
- PWM_BITS, 4: width of BRIGHTNESS and of the PWM phase counter.
- BLINK_DIV, 50: number of frames per blink half-period (>=1).
- HEX_MODE, 1: 1 = values 10..15 show A b C d E F; 0 = values 10..15 show "E".

Ports:
- CLK  in  1  system clock, 100 MHz.
- RESET  in  1  asynchronous, active-high.
- DIGITS  in  4*N_DIGITS  digit values; [3:0] is digit 0 (rightmost).
- DP_IN  in  N_DIGITS  decimal point request per digit, active-high.
- BLANK  in  N_DIGITS  force digit dark, active-high.
- BLINK_EN  in  N_DIGITS  digit blinks, active-high.
- LZ_SUPPRESS  in  1  enable leading-zero suppression.
- BRIGHTNESS  in  PWM_BITS  duty select.
- SEG_OUT  out  7  gfedcba, active-low.
- DP_OUT  out  1  decimal point segment, active-low.
- ANODE  out  N_DIGITS  digit enables, active-low.
- FRAME_TICK  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset (async) values:
  - count=0, idx=0, pwm_cnt=0, blink_cnt=0, blink_phase=0.
  - Snapshot registers all 0.
  - Outputs: ANODE all ones, SEG_OUT=7'h7F, DP_OUT=1, FRAME_TICK=0.
- Prescaler:
  - count runs 0..DIV_RATIO; carry=(count==DIV_RATIO).
  - On carry: count clears to 0 and idx advances.
- Scan index: idx increments on carry; it wraps from N_DIGITS-1 to 0.
- Frame boundary = carry while idx==N_DIGITS-1. In that same cycle:
  - FRAME_TICK=1.
  - Snapshot registers load DIGITS, DP_IN, BLANK, BLINK_EN and LZ_SUPPRESS.
- Input changes between boundaries are not displayed until the next boundary. After reset, zeros are displayed (subject to LZ_SUPPRESS) until the first boundary.
- Blink:
  - blink_cnt counts frame boundaries 0..BLINK_DIV-1.
  - On wrap, blink_phase toggles.
  - While blink_phase=1, digits with snapshot BLINK_EN set are dark.
- Leading-zero suppression (snapshot LZ=1):
  - Digit k (k>=1) is suppressed when its value and the values of all higher digits are 0.
  - Digit 0 is never suppressed.
- Dark digit: BLANK set, or blinking off, or PWM off-phase → ANODE bit=1.
- Suppressed-but-DP digit: anode on, SEG_OUT=7'h7F, DP per DP_IN.
- PWM:
  - pwm_cnt increments every CLK; it clears on carry and wraps at 2^PWM_BITS.
  - Anode is on while pwm_cnt <= BRIGHTNESS (BRIGHTNESS is not snapshotted).
  - BRIGHTNESS=max gives continuous on.
- Glyphs (gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - With HEX_MODE=0, all values >=10 show E.
- Latency: ANODE, SEG_OUT and DP_OUT are registered and lag idx/pwm_cnt by exactly one CLK. Only one ANODE bit is ever low.
- Reset mid-frame: outputs go to reset values immediately; scanning restarts at digit 0 with zero snapshot.

Decomposition:
- Package seven_seg_pkg holds:
  - glyph constants, blank pattern 7'h7F and the error glyph;
  - a decode function taking (value, hex_mode).
- Sub-module seg_glyph_dec: combinational value→glyph decoder.
- Prescaler, scan, snapshot, blink and PWM logic stay in the top level.

Test Plan:
- Reset and scan:
  - Settings: DIV_RATIO=15, N_DIGITS=4, BRIGHTNESS=15, DIGITS=16'h1234.
  - Required: after RESET, ANODE=1111 and SEG_OUT=7F. After the first FRAME_TICK, digit 0 slot shows ANODE=1110, SEG_OUT=0011001. Digit 3 slot shows ANODE=0111, SEG_OUT=1111001. Each slot lasts 16 cycles.
- Leading zeros:
  - Stimulus: DIGITS=16'h0050, LZ_SUPPRESS=1 → ANODE[3] and ANODE[2] are never low; digit 1 shows 0010010; digit 0 shows 1000000.
  - Stimulus: DIGITS=16'h0000 → only ANODE[0] ever goes low.
- PWM:
  - BRIGHTNESS=3, DIV_RATIO=15 → ANODE is low 4 of 16 cycles per slot.
  - BRIGHTNESS=15 → ANODE is low 16 of 16 cycles.
- Blink:
  - Settings: BLINK_DIV=2, BLINK_EN=4'b0001.
  - Required: digit 0 is lit in frames 0-1, dark in frames 2-3, lit in frames 4-5.
- Snapshot:
  - Stimulus: change DIGITS from 16'h1111 to 16'h2222 while digit 1 is displayed.
  - Required: remaining slots of that frame still show 1; 2 appears only after FRAME_TICK. DP_IN=0100 gives DP_OUT=0 only in the digit 2 slot.
- Glyph mode and reset:
  - Digit value 4'hA: HEX_MODE=1 shows 0001000; HEX_MODE=0 shows 0000110.
  - Assert RESET mid-slot: outputs are reset values in the same cycle; after release, digit 0 is scanned first.
